// File: rtl/seq_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : seq_gen_pkg                                            |
// | Description : Shared mode encodings, state enum and range helpers    |
// |               for the parametrised stepped-sequence generator.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package seq_gen_pkg;

  // Widest sequence the helper functions can describe; callers size-cast down.
  localparam int MAX_W = 32;

  localparam logic [1:0] MODE_EVEN = 2'b00;
  localparam logic [1:0] MODE_ODD  = 2'b01;
  localparam logic [1:0] MODE_ALL  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The reserved encoding behaves exactly like even.
  function automatic logic [1:0] norm_mode(input logic [1:0] mode);
    return (mode == 2'b11) ? MODE_EVEN : mode;
  endfunction

  // All-ones value of a w-bit range, zero-extended to MAX_W.
  function automatic logic [MAX_W-1:0] range_mask(input int w);
    logic [MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < w) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Value a sequence starts from (and returns to after a wrap).
  function automatic logic [MAX_W-1:0] first_val(input logic [1:0] mode,
                                                 input logic       dir,
                                                 input int         w);
    logic [MAX_W-1:0] m;
    logic [MAX_W-1:0] r;
    m = range_mask(w);
    case (mode)
      MODE_ODD: r = dir ? m : MAX_W'(1);
      MODE_ALL: r = dir ? m : '0;
      default:  r = dir ? (m & ~MAX_W'(1)) : '0;
    endcase
    return r;
  endfunction

  // The end of the range is simply the start of the opposite direction.
  function automatic logic [MAX_W-1:0] last_val(input logic [1:0] mode,
                                                input logic       dir,
                                                input int         w);
    return first_val(mode, ~dir, w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_gen_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : seq_gen_step                                           |
// | Description : Combinational successor value and end-of-range flag    |
// |               for the current sequence value.                        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module seq_gen_step
  import seq_gen_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic [1:0]       mode,
  input  logic             dir,
  output logic [WIDTH-1:0] q_next,
  output logic             is_last
);

  logic [WIDTH-1:0] step;

  // Modulo-2^W step in the latched direction; compare against range end.
  always_comb begin
    step    = (mode == MODE_ALL) ? WIDTH'(1) : WIDTH'(2);
    q_next  = dir ? (q - step) : (q + step);
    is_last = (q == WIDTH'(last_val(mode, dir, WIDTH)));
  end

endmodule
`default_nettype wire

// File: rtl/seq_gen_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : seq_gen_param                                          |
// | Description : Stepped even/odd/all number generator, up or down,     |
// |               with valid/ready output, loadable start, wrap or       |
// |               one-shot termination and complementary q/qbar.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module seq_gen_param
  import seq_gen_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter bit ONE_SHOT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             out_valid,
  output logic             wrap,
  output logic             done
);

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic [WIDTH-1:0] qbar_q, qbar_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  logic [1:0]       start_mode;
  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] step_next;
  logic             step_last;
  logic             xfer;

  seq_gen_step #(.WIDTH(WIDTH)) u_step (
    .q       (val_q),
    .mode    (mode_q),
    .dir     (dir_q),
    .q_next  (step_next),
    .is_last (step_last)
  );

  // First value of a sequence started this cycle: range start or load_val
  // with its LSB forced to the parity the mode demands.
  always_comb begin
    start_mode = norm_mode(mode);
    if (load) begin
      start_val = load_val;
      if (start_mode == MODE_EVEN)     start_val[0] = 1'b0;
      else if (start_mode == MODE_ODD) start_val[0] = 1'b1;
    end else begin
      start_val = WIDTH'(first_val(start_mode, dir, WIDTH));
    end
  end

  // wrap must coincide with the handshake of the last value, so it is
  // decoded from registered state and the live out_ready.
  always_comb begin
    xfer = valid_q & out_ready;
    wrap = xfer & step_last;
  end

  // Next-state logic: start is only seen outside RUN, stop only inside.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    val_d   = val_q;
    valid_d = valid_q;
    done_d  = done_q;
    case (state_q)
      RUN: begin
        if (xfer) begin
          if (step_last) begin
            if (ONE_SHOT) begin
              state_d = DONE;
              valid_d = 1'b0;
              done_d  = 1'b1;
            end else begin
              val_d = WIDTH'(first_val(mode_q, dir_q, WIDTH));
            end
          end else begin
            val_d = step_next;
          end
        end
        // A completing one-shot takes priority over a coincident stop.
        if (stop && (state_d == RUN)) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        if (start) begin
          state_d = RUN;
          mode_d  = start_mode;
          dir_d   = dir;
          val_d   = start_val;
          valid_d = 1'b1;
          done_d  = 1'b0;
        end
      end
    endcase
    qbar_d = ~val_d;
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= MODE_EVEN;
      dir_q   <= 1'b0;
      val_q   <= '0;
      qbar_q  <= '1;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      val_q   <= val_d;
      qbar_q  <= qbar_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign q         = val_q;
  assign qbar      = qbar_q;
  assign out_valid = valid_q;
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_gen_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_seq_gen_param                                       |
// | Description : Directed self-checking bench for seq_gen_param: a      |
// |               4-bit wrapping instance and a 3-bit one-shot instance. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_seq_gen_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, stop = 1'b0, load = 1'b0, dir = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] load_val = 4'd0;
  logic       out_ready = 1'b1;
  logic [3:0] q, qbar;
  logic       out_valid, wrap, done;

  logic       start_b = 1'b0, stop_b = 1'b0, out_ready_b = 1'b1;
  logic [2:0] load_val_b = 3'd0;
  logic [2:0] q_b, qbar_b;
  logic       out_valid_b, wrap_b, done_b;

  int checks = 0;
  int failures = 0;

  seq_gen_param #(.WIDTH(4), .ONE_SHOT(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .dir(dir),
    .load(load), .load_val(load_val), .out_ready(out_ready),
    .q(q), .qbar(qbar), .out_valid(out_valid), .wrap(wrap), .done(done)
  );

  seq_gen_param #(.WIDTH(3), .ONE_SHOT(1'b1)) dut_os (
    .clk(clk), .rst(rst), .start(start_b), .stop(stop_b), .mode(mode), .dir(dir),
    .load(load), .load_val(load_val_b), .out_ready(out_ready_b),
    .q(q_b), .qbar(qbar_b), .out_valid(out_valid_b), .wrap(wrap_b), .done(done_b)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle before driving or sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({q, qbar, out_valid, wrap, done} !== {4'd0, 4'hF, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_a: got q=%h qbar=%h v=%b w=%b d=%b, expected q=0 qbar=F v=0 w=0 d=0",
               q, qbar, out_valid, wrap, done);
    end
    checks++;
    if ({q_b, qbar_b, out_valid_b, wrap_b, done_b} !== {3'd0, 3'h7, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_b: got q=%h qbar=%h v=%b w=%b d=%b, expected q=0 qbar=7 v=0 w=0 d=0",
               q_b, qbar_b, out_valid_b, wrap_b, done_b);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: got v=%b, expected v=0", out_valid);
    end
  endtask

  task automatic test_even_up();
    logic [3:0] e;
    mode = 2'b00; dir = 1'b0; load = 1'b0; out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 18; i++) begin
      e = 4'((2 * i) % 16);
      checks++;
      if ({q, qbar, out_valid, wrap, done} !== {e, ~e, 1'b1, (e == 4'd14), 1'b0}) begin
        failures++;
        $display("FAIL even_up[%0d]: got q=%0d qbar=%h v=%b w=%b d=%b, expected q=%0d w=%b",
                 i, q, qbar, out_valid, wrap, done, e, (e == 4'd14));
      end
      tick();
    end
  endtask

  // Continues from test_even_up: q is 4 and the generator is running.
  task automatic test_stop();
    checks++;
    if (q !== 4'd4) begin
      failures++;
      $display("FAIL stop_pre: got q=%0d, expected q=4", q);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if ({q, qbar, out_valid, wrap} !== {4'd6, 4'd9, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL stop: got q=%0d qbar=%h v=%b w=%b, expected q=6 qbar=9 v=0 w=0",
               q, qbar, out_valid, wrap);
    end
    tick();
    checks++;
    if ({q, out_valid} !== {4'd6, 1'b0}) begin
      failures++;
      $display("FAIL stop_hold: got q=%0d v=%b, expected q=6 v=0", q, out_valid);
    end
  endtask

  task automatic test_odd_down();
    logic [3:0] e;
    mode = 2'b01; dir = 1'b1; load = 1'b0; out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      e = 4'(15 - 2 * i);
      checks++;
      if ({q, qbar, out_valid, wrap} !== {e, ~e, 1'b1, (e == 4'd1)}) begin
        failures++;
        $display("FAIL odd_down[%0d]: got q=%0d qbar=%h v=%b w=%b, expected q=%0d w=%b",
                 i, q, qbar, out_valid, wrap, e, (e == 4'd1));
      end
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_backpressure();
    mode = 2'b00; dir = 1'b0; load = 1'b0; out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (q !== 4'd6) begin
      failures++;
      $display("FAIL bp_pre: got q=%0d, expected q=6", q);
    end
    // Stall, and also try a restart with load which RUN must ignore.
    out_ready = 1'b0;
    start = 1'b1; load = 1'b1; load_val = 4'd2;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({q, out_valid, wrap} !== {4'd6, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL bp_stall[%0d]: got q=%0d v=%b w=%b, expected q=6 v=1 w=0",
                 k, q, out_valid, wrap);
      end
      tick();
    end
    start = 1'b0; load = 1'b0;
    checks++;
    if ({q, qbar, out_valid} !== {4'd6, 4'd9, 1'b1}) begin
      failures++;
      $display("FAIL bp_after_stall: got q=%0d qbar=%h v=%b, expected q=6 qbar=9 v=1",
               q, qbar, out_valid);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (q !== 4'd8) begin
      failures++;
      $display("FAIL bp_resume: got q=%0d, expected q=8", q);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_one_shot();
    logic [2:0] e;
    mode = 2'b10; dir = 1'b0; load = 1'b0; out_ready_b = 1'b1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      e = 3'(i);
      checks++;
      if ({q_b, qbar_b, out_valid_b, wrap_b, done_b} !== {e, ~e, 1'b1, (i == 7), 1'b0}) begin
        failures++;
        $display("FAIL one_shot[%0d]: got q=%0d v=%b w=%b d=%b, expected q=%0d v=1 w=%b d=0",
                 i, q_b, out_valid_b, wrap_b, done_b, e, (i == 7));
      end
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({q_b, out_valid_b, wrap_b, done_b} !== {3'd7, 1'b0, 1'b0, 1'b1}) begin
        failures++;
        $display("FAIL one_shot_done[%0d]: got q=%0d v=%b w=%b d=%b, expected q=7 v=0 w=0 d=1",
                 k, q_b, out_valid_b, wrap_b, done_b);
      end
      tick();
    end
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    checks++;
    if ({q_b, out_valid_b, done_b} !== {3'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL one_shot_restart: got q=%0d v=%b d=%b, expected q=0 v=1 d=0",
               q_b, out_valid_b, done_b);
    end
    stop_b = 1'b1;
    tick();
    stop_b = 1'b0;
  endtask

  task automatic test_load();
    logic [3:0] e;
    out_ready = 1'b1;
    mode = 2'b00; dir = 1'b0; load = 1'b1; load_val = 4'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({q, out_valid} !== {4'd6, 1'b1}) begin
      failures++;
      $display("FAIL load_even: got q=%0d v=%b, expected q=6 v=1", q, out_valid);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    mode = 2'b01; load_val = 4'd4;
    start = 1'b1;
    tick();
    start = 1'b0; load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      e = 4'(5 + 2 * i);
      checks++;
      if ({q, wrap} !== {e, (e == 4'd15)}) begin
        failures++;
        $display("FAIL load_odd[%0d]: got q=%0d w=%b, expected q=%0d w=%b",
                 i, q, wrap, e, (e == 4'd15));
      end
      tick();
    end
    checks++;
    if (q !== 4'd1) begin
      failures++;
      $display("FAIL load_wrap: got q=%0d, expected q=1", q);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    // Reserved mode behaves as even.
    mode = 2'b11; dir = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (q !== 4'd2) begin
      failures++;
      $display("FAIL reserved_mode: got q=%0d, expected q=2", q);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    mode = 2'b00; dir = 1'b0; load = 1'b0; out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    checks++;
    if (q !== 4'd10) begin
      failures++;
      $display("FAIL rst_mid_pre: got q=%0d, expected q=10", q);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({q, qbar, out_valid, wrap, done} !== {4'd0, 4'hF, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL rst_mid: got q=%0d qbar=%h v=%b w=%b d=%b, expected q=0 qbar=F v=0 w=0 d=0",
               q, qbar, out_valid, wrap, done);
    end
  endtask

  initial begin
    test_reset();
    test_even_up();
    test_stop();
    test_odd_down();
    test_backpressure();
    test_one_shot();
    test_load();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
